// File: rtl/map_ctrl.sv
// map_ctrl: queues MCU mapper writes, applies them on CPU M2 falls, switches mapper on the vector fetch.
// Optional build macro MAP_CTRL_IRQ_HIJACK_EN lets the menu switch also fire on the IRQ/BRK vector.
module map_ctrl #(
    parameter int ADDR_BITS    = 23,
    parameter int MAP_BITS     = 5,
    parameter int ARG_BITS     = 2,
    parameter int CMD_DEPTH    = 4,
    parameter int RESET_CYCLES = 255,
    localparam int REG_W       = MAP_BITS + 5 + ARG_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m2,
    input  logic [15:0]          cpu_addr,
    input  logic                 cpu_rw,
    input  logic [REG_W-1:0]     wr_reg,
    input  logic [3:0]           wr_reg_addr,
    input  logic                 wr_reg_changed,
    input  logic                 launcher_status,
    input  logic [7:0]           joy1,
    output logic [MAP_BITS-1:0]  select,
    output logic [ADDR_BITS-1:0] prg_mask,
    output logic [ADDR_BITS-1:0] chr_mask,
    output logic [ARG_BITS-1:0]  map_args,
    output logic [3:0]           launcher_ctrl,
    output logic                 cpu_reset,
    output logic [31:0]          status_reg
);

    localparam int CMD_W = REG_W + 4;
    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(RESET_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RESET_CYCLES);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(CMD_DEPTH);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ARM_APP  = 2'd1;
    localparam logic [1:0] ST_ARM_MENU = 2'd2;

    localparam logic [3:0] CMD_MAPPER   = 4'd0;
    localparam logic [3:0] CMD_LAUNCHER = 4'd1;
    localparam logic [3:0] CMD_CONTROL  = 4'd2;

    localparam logic [15:0] VEC_RESET  = 16'hFFFC;
    localparam logic [15:0] VEC_NMI_LO = 16'hFFFA;
    localparam logic [15:0] VEC_NMI_HI = 16'hFFFB;
`ifdef MAP_CTRL_IRQ_HIJACK_EN
    localparam logic [15:0] VEC_IRQ_LO = 16'hFFFE;
    localparam logic [15:0] VEC_IRQ_HI = 16'hFFFF;
`endif

    function automatic logic [ADDR_BITS-1:0] prg_mask_of(input logic [4:0] n);
        return ADDR_BITS'((64'd1 << n) - 64'd1);
    endfunction

    function automatic logic [ADDR_BITS-1:0] chr_mask_of(input logic [4:0] n);
        return (n == 5'd0) ? '0 : ADDR_BITS'(64'd1 << n);
    endfunction

    // Low vector byte: the menu switch commits select here.
    function automatic logic menu_commit_addr(input logic [15:0] a);
`ifdef MAP_CTRL_IRQ_HIJACK_EN
        return (a == VEC_NMI_LO) || (a == VEC_IRQ_LO);
`else
        return (a == VEC_NMI_LO);
`endif
    endfunction

    function automatic logic menu_done_addr(input logic [15:0] a);
`ifdef MAP_CTRL_IRQ_HIJACK_EN
        return (a == VEC_NMI_HI) || (a == VEC_IRQ_HI);
`else
        return (a == VEC_NMI_HI);
`endif
    endfunction

    logic [2:0]           m2_s_q, m2_s_d;
    logic [2:0]           wc_s_q, wc_s_d;
    logic [15:0]          addr_q, addr_d;
    logic                 rw_q, rw_d;
    logic [CMD_W-1:0]     fifo_q [CMD_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 ovf_q, ovf_d;
    logic [1:0]           state_q, state_d;
    logic [MAP_BITS-1:0]  select_reg_q, select_reg_d;
    logic [MAP_BITS-1:0]  pending_q, pending_d;
    logic [ADDR_BITS-1:0] prg_mask_q, prg_mask_d;
    logic [ADDR_BITS-1:0] chr_mask_q, chr_mask_d;
    logic [ARG_BITS-1:0]  args_q, args_d;
    logic                 load_menu_q, load_menu_d;
    logic                 load_app_q, load_app_d;
    logic                 halt_q, halt_d;
    logic                 buffer_num_q, buffer_num_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 cpu_reset_q, cpu_reset_d;
    logic [7:0]           joy_q, joy_d;
    logic                 lstat_q, lstat_d;

    logic                 m2_fall, wc_edge;
    logic                 fifo_full, push, pop, vec_commit;
    logic                 hijack;
    logic [CMD_W-1:0]     cmd;
    logic [3:0]           cmd_addr;
    logic [REG_W-1:0]     cmd_data;
    logic [MAP_BITS-1:0]  cmd_map;
    logic [4:0]           cmd_size;
    logic [ARG_BITS-1:0]  cmd_args;

    assign m2_fall   = m2_s_q[2] & ~m2_s_q[1];
    assign wc_edge   = wc_s_q[1] ^ wc_s_q[2];
    assign fifo_full = (level_q == LVL_FULL);
    assign push      = wc_edge && !fifo_full;

    assign cmd      = fifo_q[rd_ptr_q];
    assign cmd_addr = cmd[CMD_W-1:REG_W];
    assign cmd_data = cmd[REG_W-1:0];
    assign cmd_map  = cmd_data[MAP_BITS-1:0];
    assign cmd_size = cmd_data[MAP_BITS+4:MAP_BITS];
    assign cmd_args = cmd_data[REG_W-1:MAP_BITS+5];

    // Live-pin hijack so the vector fetch itself already sees the new mapper.
    assign hijack = cpu_rw && (((state_q == ST_ARM_APP) && (cpu_addr == VEC_RESET)) ||
                               ((state_q == ST_ARM_MENU) && menu_commit_addr(cpu_addr)));
    assign select = hijack ? pending_q : select_reg_q;

    always_comb begin
        m2_s_d       = {m2_s_q[1:0], m2};
        wc_s_d       = {wc_s_q[1:0], wr_reg_changed};
        addr_d       = addr_q;
        rw_d         = rw_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        ovf_d        = ovf_q;
        state_d      = state_q;
        select_reg_d = select_reg_q;
        pending_d    = pending_q;
        prg_mask_d   = prg_mask_q;
        chr_mask_d   = chr_mask_q;
        args_d       = args_q;
        load_menu_d  = load_menu_q;
        load_app_d   = load_app_q;
        halt_d       = halt_q;
        buffer_num_d = buffer_num_q;
        joy_d        = joy_q;
        lstat_d      = lstat_q;
        vec_commit   = 1'b0;

        if (m2_s_q[1]) begin
            addr_d = cpu_addr;
            rw_d   = cpu_rw;
        end

        if (m2_fall) begin
            cnt_d   = '0;
            joy_d   = joy1;
            lstat_d = launcher_status;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        cpu_reset_d = (cnt_d == CNT_MAX);

        // Vector commits take the M2 fall; a queued command waits for the next one.
        if (m2_fall && rw_q) begin
            if ((state_q == ST_ARM_APP) && (addr_q == VEC_RESET)) begin
                select_reg_d = pending_q;
                load_app_d   = 1'b0;
                state_d      = ST_IDLE;
                vec_commit   = 1'b1;
            end else if ((state_q == ST_ARM_MENU) && menu_commit_addr(addr_q)) begin
                select_reg_d = pending_q;
                vec_commit   = 1'b1;
            end else if ((state_q == ST_ARM_MENU) && menu_done_addr(addr_q)) begin
                load_menu_d = 1'b0;
                halt_d      = 1'b0;
                state_d     = ST_IDLE;
                vec_commit  = 1'b1;
            end
        end

        pop = m2_fall && !vec_commit && (level_q != '0);

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case (cmd_addr)
                CMD_MAPPER: begin
                    pending_d  = cmd_map;
                    args_d     = cmd_args;
                    prg_mask_d = prg_mask_of(cmd_size);
                    chr_mask_d = chr_mask_of(cmd_size);
                    load_app_d = 1'b1;
                    state_d    = ST_ARM_APP;
                end
                CMD_LAUNCHER: begin
                    buffer_num_d = cmd_data[0];
                    halt_d       = halt_q | cmd_data[1];
                    if (cmd_data[2]) begin
                        load_menu_d = 1'b1;
                        pending_d   = '0;
                        state_d     = ST_ARM_MENU;
                    end
                end
                CMD_CONTROL: begin
                    if (cmd_data[0]) begin
                        state_d     = ST_IDLE;
                        load_app_d  = 1'b0;
                        load_menu_d = 1'b0;
                        pending_d   = select_reg_q;
                    end
                    if (cmd_data[1]) begin
                        ovf_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (wc_edge && fifo_full) begin
            ovf_d = 1'b1;
        end
        level_d = level_q + LVL_W'(push) - LVL_W'(pop);

        // Console held in reset: routing parked on mapper 0; the first M2 fall releases it.
        if (cpu_reset_q && !m2_fall) begin
            select_reg_d = '0;
            pending_d    = '0;
            prg_mask_d   = '0;
            chr_mask_d   = '0;
            args_d       = '0;
            load_menu_d  = 1'b0;
            load_app_d   = 1'b0;
            halt_d       = 1'b0;
            buffer_num_d = 1'b0;
            state_d      = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {wr_reg_addr, wr_reg};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m2_s_q       <= '0;
            wc_s_q       <= '0;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            ovf_q        <= 1'b0;
            state_q      <= ST_IDLE;
            select_reg_q <= '0;
            pending_q    <= '0;
            prg_mask_q   <= '0;
            chr_mask_q   <= '0;
            args_q       <= '0;
            load_menu_q  <= 1'b0;
            load_app_q   <= 1'b0;
            halt_q       <= 1'b0;
            buffer_num_q <= 1'b0;
            cnt_q        <= '0;
            cpu_reset_q  <= 1'b0;
            joy_q        <= '0;
            lstat_q      <= 1'b0;
        end else begin
            m2_s_q       <= m2_s_d;
            wc_s_q       <= wc_s_d;
            addr_q       <= addr_d;
            rw_q         <= rw_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            ovf_q        <= ovf_d;
            state_q      <= state_d;
            select_reg_q <= select_reg_d;
            pending_q    <= pending_d;
            prg_mask_q   <= prg_mask_d;
            chr_mask_q   <= chr_mask_d;
            args_q       <= args_d;
            load_menu_q  <= load_menu_d;
            load_app_q   <= load_app_d;
            halt_q       <= halt_d;
            buffer_num_q <= buffer_num_d;
            cnt_q        <= cnt_d;
            cpu_reset_q  <= cpu_reset_d;
            joy_q        <= joy_d;
            lstat_q      <= lstat_d;
        end
    end

    assign prg_mask      = prg_mask_q;
    assign chr_mask      = chr_mask_q;
    assign map_args      = args_q;
    assign launcher_ctrl = {load_menu_q, load_app_q, halt_q, buffer_num_q};
    assign cpu_reset     = cpu_reset_q;
    assign status_reg    = {16'd0, 3'(level_q), state_q, ovf_q, cpu_reset_q, lstat_q, joy_q};

endmodule

// File: tb/tb_map_ctrl.sv
// Directed bench for map_ctrl: mapper/menu switching, FIFO overflow, console-reset detection.
module tb_map_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        m2;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [11:0] wr_reg;
    logic [3:0]  wr_reg_addr;
    logic        wr_reg_changed;
    logic        launcher_status;
    logic [7:0]  joy1;
    logic [4:0]  select;
    logic [22:0] prg_mask;
    logic [22:0] chr_mask;
    logic [1:0]  map_args;
    logic [3:0]  launcher_ctrl;
    logic        cpu_reset;
    logic [31:0] status_reg;

    int checks = 0;
    int errors = 0;
    logic [4:0] sel_exp;

    map_ctrl dut (
        .clk(clk), .reset(reset), .m2(m2), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
        .wr_reg(wr_reg), .wr_reg_addr(wr_reg_addr), .wr_reg_changed(wr_reg_changed),
        .launcher_status(launcher_status), .joy1(joy1), .select(select),
        .prg_mask(prg_mask), .chr_mask(chr_mask), .map_args(map_args),
        .launcher_ctrl(launcher_ctrl), .cpu_reset(cpu_reset), .status_reg(status_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mcu_write(input logic [3:0] a, input logic [11:0] d);
        wr_reg         = d;
        wr_reg_addr    = a;
        wr_reg_changed = ~wr_reg_changed;
        clk_n(4);
    endtask

    task automatic bus_start(input logic [15:0] a);
        cpu_addr = a;
        cpu_rw   = 1'b1;
        m2       = 1'b1;
        clk_n(4);
    endtask

    task automatic bus_end();
        m2 = 1'b0;
        clk_n(4);
    endtask

    task automatic bus(input logic [15:0] a);
        bus_start(a);
        bus_end();
    endtask

    initial begin
        reset = 1'b1; m2 = 1'b0; cpu_addr = 16'h0000; cpu_rw = 1'b1;
        wr_reg = '0; wr_reg_addr = '0; wr_reg_changed = 1'b0;
        launcher_status = 1'b1; joy1 = 8'h5A;
        clk_n(3);
        reset = 1'b0;
        clk_n(1);

        // Reset state
        chk("rst_select", 32'(select), 32'd0);
        chk("rst_prg", 32'(prg_mask), 32'd0);
        chk("rst_chr", 32'(chr_mask), 32'd0);
        chk("rst_launcher", 32'(launcher_ctrl), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("rst_status", status_reg, 32'd0);

        // Mapper 3, size 2^5: pop on FFF0, switch on FFFC
        mcu_write(4'd0, 12'h0A3);
        bus_start(16'hFFF0);
        chk("t1_sel_idle", 32'(select), 32'd0);
        bus_end();
        chk("t1_state_arm", 32'(status_reg[12:11]), 32'd1);
        chk("t1_load_app", 32'(launcher_ctrl), 32'b0100);
        chk("t1_prg", 32'(prg_mask), 32'h1F);
        chk("t1_chr", 32'(chr_mask), 32'h20);
        chk("t1_joy_lstat", 32'(status_reg[8:0]), 32'h15A);
        bus_start(16'hFFFC);
        chk("t1_sel_hijack", 32'(select), 32'd3);
        bus_end();
        chk("t1_sel_commit", 32'(select), 32'd3);
        chk("t1_state_idle", 32'(status_reg[12:11]), 32'd0);
        chk("t1_launcher", 32'(launcher_ctrl), 32'd0);

        // FIFO overflow, then CONTROL clear-ovf queued behind
        for (int i = 0; i < 5; i++) mcu_write(4'hF, 12'(i));
        chk("t2_level_full", 32'(status_reg[15:13]), 32'd4);
        chk("t2_ovf_set", 32'(status_reg[10]), 32'd1);
        bus(16'hFFF0);
        mcu_write(4'd2, 12'h002);
        chk("t2_level_refill", 32'(status_reg[15:13]), 32'd4);
        for (int i = 0; i < 3; i++) bus(16'hFFF0);
        chk("t2_ovf_pending", 32'(status_reg[10]), 32'd1);
        chk("t2_level_one", 32'(status_reg[15:13]), 32'd1);
        bus(16'hFFF0);
        chk("t2_ovf_clear", 32'(status_reg[10]), 32'd0);
        chk("t2_level_empty", 32'(status_reg[15:13]), 32'd0);

        // Launcher menu switch via NMI vector (with halt)
        mcu_write(4'd1, 12'h006);
        bus(16'hFFF0);
        chk("t3_state_menu", 32'(status_reg[12:11]), 32'd2);
        chk("t3_launcher", 32'(launcher_ctrl), 32'b1010);
        chk("t3_sel_before", 32'(select), 32'd3);
        bus_start(16'hFFFA);
        chk("t3_sel_hijack", 32'(select), 32'd0);
        bus_end();
        bus(16'hFFFB);
        chk("t3_launcher_done", 32'(launcher_ctrl), 32'd0);
        chk("t3_state_idle", 32'(status_reg[12:11]), 32'd0);
        chk("t3_sel_after", 32'(select), 32'd0);

        // IRQ vector while menu armed
        mcu_write(4'd0, 12'h065);
        bus(16'hFFF0);
        bus(16'hFFFC);
        chk("t6_sel5", 32'(select), 32'd5);
        mcu_write(4'd1, 12'h004);
        bus(16'hFFF0);
        chk("t6_state_menu", 32'(status_reg[12:11]), 32'd2);
`ifdef MAP_CTRL_IRQ_HIJACK_EN
        sel_exp = 5'd0;
`else
        sel_exp = 5'd5;
`endif
        bus_start(16'hFFFE);
        chk("t6_sel_irq", 32'(select), 32'(sel_exp));
        bus_end();
        chk("t6_sel_irq_after", 32'(select), 32'(sel_exp));
        mcu_write(4'd2, 12'h001);
        bus(16'hFFF0);
        chk("t6_abort_state", 32'(status_reg[12:11]), 32'd0);
        chk("t6_abort_launcher", 32'(launcher_ctrl), 32'd0);

        // MAPPER then abort before FFFC
        mcu_write(4'd0, 12'h867);
        mcu_write(4'd2, 12'h001);
        bus(16'hFFF0);
        chk("t5_state_arm", 32'(status_reg[12:11]), 32'd1);
        chk("t5_args", 32'(map_args), 32'd2);
        chk("t5_prg", 32'(prg_mask), 32'h7);
        chk("t5_chr", 32'(chr_mask), 32'h8);
        bus(16'hFFF0);
        chk("t5_state_idle", 32'(status_reg[12:11]), 32'd0);
        bus_start(16'hFFFC);
        chk("t5_sel_no_hijack", 32'(select), 32'(sel_exp));
        bus_end();
        chk("t5_sel_unchanged", 32'(select), 32'(sel_exp));

        // Console reset from M2 inactivity
        clk_n(250);
        chk("t4_not_yet", 32'(cpu_reset), 32'd0);
        clk_n(10);
        chk("t4_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t4_status9", 32'(status_reg[9]), 32'd1);
        chk("t4_select", 32'(select), 32'd0);
        chk("t4_prg", 32'(prg_mask), 32'd0);
        chk("t4_chr", 32'(chr_mask), 32'd0);
        chk("t4_args", 32'(map_args), 32'd0);
        mcu_write(4'd0, 12'h089);
        chk("t4_fifo_kept", 32'(status_reg[15:13]), 32'd1);
        chk("t4_prg_held", 32'(prg_mask), 32'd0);
        bus_start(16'hFFF0);
        chk("t4_still_reset", 32'(cpu_reset), 32'd1);
        m2 = 1'b0;
        clk_n(2);
        chk("t4_before_fall", 32'(cpu_reset), 32'd1);
        clk_n(1);
        chk("t4_released", 32'(cpu_reset), 32'd0);
        chk("t4_pop_prg", 32'(prg_mask), 32'hF);
        chk("t4_pop_chr", 32'(chr_mask), 32'h10);
        chk("t4_pop_state", 32'(status_reg[12:11]), 32'd1);
        clk_n(1);

        // Port reset mid-switch
        reset = 1'b1;
        clk_n(2);
        reset = 1'b0;
        clk_n(1);
        chk("r_state", 32'(status_reg[12:11]), 32'd0);
        chk("r_status", status_reg, 32'd0);
        chk("r_prg", 32'(prg_mask), 32'd0);
        chk("r_launcher", 32'(launcher_ctrl), 32'd0);
        chk("r_select", 32'(select), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
